// File: rtl/lfsr4_prbs_checker.sv
// Receive-side PRBS checker for the 4-bit x^4+x^3+1 Fibonacci LFSR stream.
// Seeds a predictor from the line, hunts for lock, then free-runs and counts bit errors.
module lfsr4_prbs_checker #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       hist
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(ERR_THRESH + 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0]  MissLast  = MissW'(ERR_THRESH - 1);

  localparam logic [1:0] StSeed   = 2'd0;
  localparam logic [1:0] StHunt   = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        hist_q, hist_d;
  logic [1:0]        fill_q, fill_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [MissW-1:0]  miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic             pred;
  logic             count_err;
  logic [CNT_W-1:0] cnt_base;

  // b[n+4] = b[n+1] ^ b[n]
  assign pred = hist_q[3] ^ hist_q[2];

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    count_err = 1'b0;
    if (din_valid) begin
      case (state_q)
        StSeed: begin
          hist_d = {hist_q[2:0], din};
          fill_d = fill_q + 2'd1;
          if (fill_q == 2'd3) begin
            state_d = StHunt;
            match_d = '0;
          end
        end
        StHunt: begin
          hist_d = {hist_q[2:0], din};
          // An all-zero history predicts zero forever, so it must never count as a match.
          if ((din == pred) && (hist_q != 4'd0)) begin
            match_d = match_q + MatchW'(1);
            if (match_q == MatchLast) begin
              state_d = StLocked;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          hist_d = {hist_q[2:0], pred};
          if (din != pred) begin
            count_err = 1'b1;
            miss_d    = miss_q + MissW'(1);
            if (miss_q == MissLast) begin
              state_d = StSeed;
              hist_d  = 4'd0;
              fill_d  = 2'd0;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = StSeed;
          hist_d  = 4'd0;
          fill_d  = 2'd0;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d    = (state_d == StLocked);
    err_d       = count_err;
    // Clear takes effect first so a same-edge error leaves a count of one.
    cnt_base    = clr_err ? '0 : err_count_q;
    err_count_d = (count_err && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StSeed;
      hist_q      <= 4'd0;
      fill_q      <= 2'd0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign hist      = hist_q;

endmodule
